// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmitter with write FIFO, runtime frame
// format, programmable baud divisor and optional CTS gating.
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   wr_en, wr_data      FIFO write port (byte sent LSB first)
//   divisor             clocks per baud tick (0 behaves as 1)
//   data_bits           data length: 0..3 -> 5..8 bits
//   parity_en/odd       parity enable / odd select
//   stop2               two stop bits when set
//   cts_en, cts_n       CTS gating enable, async active-low CTS
//   tx                  serial output, idles high
//   busy                frame in progress
//   full/empty/level    FIFO status (registered)
//   overflow            one-cycle pulse per dropped write
module uart_tx_core #(
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic [DIV_W-1:0]              divisor,
  input  logic [1:0]                    data_bits,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          stop2,
  input  logic                          cts_en,
  input  logic                          cts_n,
  output logic                          tx,
  output logic                          busy,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int OSW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [AW:0]      DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] DIV_ONE = 1;
  localparam logic [OSW-1:0]   OS_ONE  = 1;
  localparam logic [OSW-1:0]   OS_LAST = OSW'(OVERSAMPLE - 1);

  logic [7:0] mem [FIFO_DEPTH];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  logic        full_q, full_d;
  logic        empty_q, empty_d;
  logic        overflow_q, overflow_d;
  logic        cts_s1_q, cts_s2_q;

  logic [2:0]       state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_q, bit_d;
  logic [2:0]       last_q, last_d;
  logic [DIV_W-1:0] tick_q, tick_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [OSW-1:0]   os_q, os_d;
  logic             par_en_q, par_en_d;
  logic             stop2_q, stop2_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;

  logic       push, drop, pop, load;
  logic       cts_ok, can_start;
  logic       tick, bit_done;
  logic [7:0] head, mask;
  logic [DIV_W-1:0] eff_div;

  assign push      = wr_en && !full_q;
  assign drop      = wr_en && full_q;
  assign cts_ok    = !cts_en || !cts_s2_q;
  assign can_start = !empty_q && cts_ok;
  assign head      = mem[rd_ptr_q[AW-1:0]];
  assign mask      = 8'hFF >> (3'd3 - {1'b0, data_bits});
  assign eff_div   = (divisor == '0) ? DIV_ONE : divisor;
  assign tick      = (tick_q == div_q - DIV_ONE);
  assign bit_done  = tick && (os_q == OS_LAST);

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    last_d   = last_q;
    div_d    = div_q;
    par_en_d = par_en_q;
    stop2_d  = stop2_q;
    par_d    = par_q;
    load     = 1'b0;
    tick_d   = tick ? '0 : tick_q + DIV_ONE;
    os_d     = os_q;
    if (tick) begin
      os_d = (os_q == OS_LAST) ? '0 : os_q + OS_ONE;
    end

    case (state_q)
      S_IDLE: begin
        if (can_start) load = 1'b1;
      end
      S_START: begin
        if (bit_done) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_q == last_q) begin
            bit_d   = '0;
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_done) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          if (stop2_q && bit_q == 3'd0) begin
            bit_d = 3'd1;
          end else if (can_start) begin
            // chain straight into the next frame, no idle cycle
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      state_d  = S_START;
      shift_d  = head;
      div_d    = eff_div;
      last_d   = {1'b1, data_bits};
      par_en_d = parity_en;
      stop2_d  = stop2;
      par_d    = (^(head & mask)) ^ parity_odd;
      tick_d   = '0;
      os_d     = '0;
      bit_d    = '0;
    end

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_comb begin
    pop        = load;
    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    level_d    = level_q;
    if (push && !pop) level_d = level_q + PTR_ONE;
    if (pop && !push) level_d = level_q - PTR_ONE;
    full_d     = (level_d == DEPTH_L);
    empty_d    = (level_d == '0);
    overflow_d = drop;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      cts_s1_q   <= 1'b1;
      cts_s2_q   <= 1'b1;
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_q      <= '0;
      last_q     <= '0;
      tick_q     <= '0;
      div_q      <= DIV_ONE;
      os_q       <= '0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      cts_s1_q   <= cts_n;
      cts_s2_q   <= cts_s1_q;
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      last_q     <= last_d;
      tick_q     <= tick_d;
      div_q      <= div_d;
      os_q       <= os_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != S_IDLE);
  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: directed + randomized checks of uart_tx_core
// against a bit-list frame model.
module tb_uart_tx_core;
  localparam int DEPTH = 16;
  localparam int OS    = 16;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = '0;
  logic [DW-1:0] divisor = 16'd2;
  logic [1:0]    data_bits = 2'd3;
  logic          parity_en = 1'b0;
  logic          parity_odd = 1'b0;
  logic          stop2 = 1'b0;
  logic          cts_en = 1'b0;
  logic          cts_n = 1'b1;
  logic          tx, busy, full, empty, overflow;
  logic [4:0]    level;

  int tests = 0;
  int fails = 0;
  bit exp_bits[$];
  logic [7:0] data_q[$];

  uart_tx_core #(
    .FIFO_DEPTH(DEPTH), .OVERSAMPLE(OS), .DIV_W(DW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en), .wr_data(wr_data),
    .divisor(divisor), .data_bits(data_bits),
    .parity_en(parity_en), .parity_odd(parity_odd),
    .stop2(stop2), .cts_en(cts_en), .cts_n(cts_n),
    .tx(tx), .busy(busy), .full(full), .empty(empty),
    .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int period_of(input int d);
    return (d == 0 ? 1 : d) * OS;
  endfunction

  // frame = start, nd data bits LSB first, optional parity, stops
  task automatic model_frame(input logic [7:0] b, input int nd,
                             input bit pen, input bit podd,
                             input bit s2);
    int ones;
    ones = 0;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int k = 0; k < nd; k++) begin
      exp_bits.push_back(b[k]);
      ones += int'(b[k]);
    end
    if (pen) exp_bits.push_back(bit'((ones % 2) ^ int'(podd)));
    exp_bits.push_back(1'b1);
    if (s2) exp_bits.push_back(1'b1);
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_data = b;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [7:0] b,
                             input int p, input int exp_wait,
                             input bit busy_after, input int mid_div,
                             input bit mid_cts);
    int w, n;
    logic obs;
    bit bsy_ok;
    w = 0;
    while (tx !== 1'b0 && w < 4000) begin
      @(negedge clk);
      w++;
    end
    chk($sformatf("%s_start", tag), 32'(w < 4000), 1);
    if (exp_wait >= 0) chk($sformatf("%s_wait", tag), w, exp_wait);
    model_frame(b, int'(data_bits) + 5, parity_en, parity_odd, stop2);
    n = exp_bits.size();
    for (int k = 0; k < n; k++) begin
      obs = exp_bits[k];
      bsy_ok = 1'b1;
      for (int j = 0; j < p; j++) begin
        if (tx !== exp_bits[k]) obs = tx;
        if (busy !== 1'b1) bsy_ok = 1'b0;
        if (k == n / 2 && j == 0) begin
          if (mid_div >= 0) divisor = DW'(mid_div);
          if (mid_cts) cts_n = 1'b1;
        end
        @(negedge clk);
      end
      chk($sformatf("%s_bit%0d", tag, k), obs, exp_bits[k]);
      chk($sformatf("%s_busy%0d", tag, k), bsy_ok, 1);
    end
    chk($sformatf("%s_busy_after", tag), busy, busy_after);
    if (!busy_after) chk($sformatf("%s_tx_idle", tag), tx, 1);
  endtask

  task automatic hold_idle(input string tag, input int cycles);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    chk(tag, ok, 1);
  endtask

  initial begin
    logic [7:0] b;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    reset_n = 1'b1;
    @(negedge clk);

    divisor = 2; data_bits = 3; parity_en = 0; stop2 = 0;
    write_byte(8'hA5);
    chk("wr_empty", empty, 0);
    chk("wr_level", level, 1);
    check_frame("8n1", 8'hA5, 32, 1, 0, -1, 0);

    data_bits = 2; parity_en = 1; parity_odd = 0; stop2 = 1;
    write_byte(8'hA5);
    check_frame("7e2", 8'hA5, 32, 1, 0, -1, 0);

    parity_odd = 1; stop2 = 0;
    write_byte(8'hA5);
    check_frame("7o1", 8'hA5, 32, 1, 0, -1, 0);

    divisor = 0; data_bits = 3; parity_en = 0;
    write_byte(8'h3C);
    check_frame("div0", 8'h3C, 16, 1, 0, -1, 0);

    divisor = 1;
    write_byte(8'h81);
    write_byte(8'h7E);
    chk("level_pushpop", level, 1);
    check_frame("cfg_a", 8'h81, 16, 0, 1, 3, 0);
    check_frame("cfg_b", 8'h7E, 48, 0, 0, -1, 0);

    for (int r = 0; r < 6; r++) begin
      divisor    = DW'($urandom_range(0, 3));
      data_bits  = 2'($urandom_range(0, 3));
      parity_en  = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      stop2      = 1'($urandom_range(0, 1));
      b = 8'($urandom);
      write_byte(b);
      check_frame($sformatf("rnd%0d", r), b,
                  period_of(int'(divisor)), 1, 0, -1, 0);
    end

    divisor = 1; data_bits = 3; parity_en = 0; stop2 = 0;
    cts_en = 1; cts_n = 1;
    repeat (2) @(negedge clk);
    write_byte(8'h55);
    hold_idle("cts_hold", 20);
    chk("cts_level", level, 1);
    cts_n = 0;
    @(negedge clk);
    chk("cts_lat1", tx, 1);
    @(negedge clk);
    chk("cts_lat2", tx, 1);
    wr_data = 8'hC3;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    chk("cts_start", tx, 0);
    chk("level_pushpop2", level, 1);
    check_frame("cts", 8'h55, 16, 0, 0, -1, 1);
    hold_idle("cts_hold2", 30);
    chk("cts_level2", level, 1);
    cts_n = 0;
    check_frame("cts2", 8'hC3, 16, 3, 0, -1, 0);

    cts_n = 1;
    repeat (3) @(negedge clk);
    data_q.delete();
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      if (i < 16) data_q.push_back(b);
      wr_data = b;
      wr_en = 1'b1;
      @(negedge clk);
      chk($sformatf("fill_ovf%0d", i), overflow, 32'(i == 16));
    end
    wr_en = 1'b0;
    @(negedge clk);
    chk("ovf_pulse_end", overflow, 0);
    chk("fill_level", level, 16);
    chk("fill_full", full, 1);
    chk("fill_tx", tx, 1);
    cts_n = 0;
    repeat (2) @(negedge clk);
    wr_data = 8'hEE;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    chk("ovf_with_pop", overflow, 1);
    chk("pop_level", level, 15);
    chk("pop_full", full, 0);
    for (int i = 0; i < 16; i++) begin
      check_frame($sformatf("fill%0d", i), data_q[i], 16,
                  0, i < 15, -1, 0);
    end
    chk("drain_level", level, 0);
    chk("drain_empty", empty, 1);

    cts_en = 0;
    write_byte(8'h96);
    write_byte(8'h69);
    repeat (48) @(negedge clk);
    chk("mid_busy", busy, 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mrst_tx", tx, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_empty", empty, 1);
    chk("mrst_level", level, 0);
    reset_n = 1'b1;
    hold_idle("mrst_idle", 40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
